bomb_map_gen: RTL and testbench

- Consumes the 4-bit random stream from the LFSR stage and builds the GRID_W x GRID_H playfield map at round start.
- Cell classes: fixed pillars, empty, brick, brick hiding a power-up.
- Holds the map as register storage.
- Serves a registered read port to the renderer/player logic and a destroy port to the bomb/explosion logic.
- Tracks the number of bricks remaining.

---
 rtl/bomb_map_gen.sv | 186 ++++++++++++++++++
 tb/tb_bomb_map_gen.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bomb_map_gen.sv
// Playfield map generator: fills the grid row-major from the LFSR stream at round start,
// then serves a registered read port and a brick-destroy port while tracking bricks left.
module bomb_map_gen #(
    parameter int GRID_W = 11,
    parameter int GRID_H = 9
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] rnd,
    input  logic       start,
    output logic       busy,
    output logic       done,
    input  logic [3:0] rd_x,
    input  logic [3:0] rd_y,
    output logic [2:0] rd_cell,
    input  logic       dst_valid,
    input  logic [3:0] dst_x,
    input  logic [3:0] dst_y,
    output logic       dst_hit,
    output logic [7:0] brick_count
);

    localparam int CELLS = GRID_W * GRID_H;
    localparam int IDX_W = (CELLS > 1) ? $clog2(CELLS) : 1;

    localparam logic [3:0] X_LAST = 4'(GRID_W - 1);
    localparam logic [3:0] X_PREV = 4'(GRID_W - 2);
    localparam logic [3:0] Y_LAST = 4'(GRID_H - 1);
    localparam logic [3:0] Y_PREV = 4'(GRID_H - 2);

    localparam logic [2:0] CELL_EMPTY    = 3'd0;
    localparam logic [2:0] CELL_PILLAR   = 3'd1;
    localparam logic [2:0] CELL_BRICK    = 3'd2;
    localparam logic [2:0] CELL_BRICK_PU = 3'd3;
    localparam logic [2:0] CELL_POWERUP  = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GEN,
        ST_READY
    } state_t;

    state_t           state_reg, state_next;
    logic [3:0]       cur_x_reg, cur_x_next;
    logic [3:0]       cur_y_reg, cur_y_next;
    logic [7:0]       brick_count_reg, brick_count_next;
    logic             dst_hit_reg, dst_hit_next;
    logic [2:0]       rd_cell_reg;
    logic [2:0]       cells_reg [CELLS];

    logic             gen_we;
    logic [2:0]       gen_val;
    logic             gen_safe;
    logic             dst_we;
    logic [2:0]       dst_val;
    logic [2:0]       dst_old;
    logic             dst_oob;
    logic             rd_oob;
    logic [IDX_W-1:0] gen_idx, dst_idx, rd_idx;

    function automatic logic [IDX_W-1:0] cell_index(input logic [3:0] x, input logic [3:0] y);
        logic [8:0] full;
        full = 9'(y) * 9'(GRID_W) + 9'(x);
        return full[IDX_W-1:0];
    endfunction

    assign gen_idx = cell_index(cur_x_reg, cur_y_reg);
    assign dst_idx = cell_index(dst_x, dst_y);
    assign rd_idx  = cell_index(rd_x, rd_y);

    assign rd_oob  = ({1'b0, rd_x} >= 5'(GRID_W)) || ({1'b0, rd_y} >= 5'(GRID_H));
    assign dst_oob = ({1'b0, dst_x} >= 5'(GRID_W)) || ({1'b0, dst_y} >= 5'(GRID_H));
    assign dst_old = cells_reg[dst_idx];

    // Player spawn corners must stay clear so nobody starts boxed in.
    assign gen_safe = ((cur_y_reg == 4'd0) && (cur_x_reg <= 4'd1))
                   || ((cur_x_reg == 4'd0) && (cur_y_reg == 4'd1))
                   || ((cur_y_reg == Y_LAST) && ((cur_x_reg == X_LAST) || (cur_x_reg == X_PREV)))
                   || ((cur_x_reg == X_LAST) && (cur_y_reg == Y_PREV));

    always_comb begin
        gen_val = CELL_EMPTY;
        if (cur_x_reg[0] && cur_y_reg[0]) begin
            gen_val = CELL_PILLAR;
        end else if (!gen_safe) begin
            case (rnd)
                4'd2, 4'd4: gen_val = CELL_BRICK;
                4'd8:       gen_val = CELL_BRICK_PU;
                default:    gen_val = CELL_EMPTY;
            endcase
        end
    end

    always_comb begin
        state_next       = state_reg;
        cur_x_next       = cur_x_reg;
        cur_y_next       = cur_y_reg;
        brick_count_next = brick_count_reg;
        dst_hit_next     = 1'b0;
        gen_we           = 1'b0;
        dst_we           = 1'b0;
        dst_val          = CELL_EMPTY;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next       = ST_GEN;
                    cur_x_next       = 4'd0;
                    cur_y_next       = 4'd0;
                    brick_count_next = 8'd0;
                end
            end
            ST_GEN: begin
                gen_we = 1'b1;
                if ((gen_val == CELL_BRICK) || (gen_val == CELL_BRICK_PU)) begin
                    brick_count_next = brick_count_reg + 8'd1;
                end
                if (cur_x_reg == X_LAST) begin
                    cur_x_next = 4'd0;
                    if (cur_y_reg == Y_LAST) begin
                        state_next = ST_READY;
                    end else begin
                        cur_y_next = cur_y_reg + 4'd1;
                    end
                end else begin
                    cur_x_next = cur_x_reg + 4'd1;
                end
            end
            ST_READY: begin
                // A regeneration request outranks a destroy arriving in the same cycle.
                if (start) begin
                    state_next       = ST_GEN;
                    cur_x_next       = 4'd0;
                    cur_y_next       = 4'd0;
                    brick_count_next = 8'd0;
                end else if (dst_valid && !dst_oob) begin
                    if (dst_old == CELL_BRICK) begin
                        dst_we           = 1'b1;
                        dst_val          = CELL_EMPTY;
                        dst_hit_next     = 1'b1;
                        brick_count_next = brick_count_reg - 8'd1;
                    end else if (dst_old == CELL_BRICK_PU) begin
                        dst_we           = 1'b1;
                        dst_val          = CELL_POWERUP;
                        dst_hit_next     = 1'b1;
                        brick_count_next = brick_count_reg - 8'd1;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            cur_x_reg       <= 4'd0;
            cur_y_reg       <= 4'd0;
            brick_count_reg <= 8'd0;
            dst_hit_reg     <= 1'b0;
            rd_cell_reg     <= CELL_EMPTY;
            for (int i = 0; i < CELLS; i++) begin
                cells_reg[i] <= CELL_EMPTY;
            end
        end else begin
            state_reg       <= state_next;
            cur_x_reg       <= cur_x_next;
            cur_y_reg       <= cur_y_next;
            brick_count_reg <= brick_count_next;
            dst_hit_reg     <= dst_hit_next;
            // Read samples the array before this edge's write lands.
            rd_cell_reg     <= rd_oob ? CELL_PILLAR : cells_reg[rd_idx];
            if (gen_we) begin
                cells_reg[gen_idx] <= gen_val;
            end else if (dst_we) begin
                cells_reg[dst_idx] <= dst_val;
            end
        end
    end

    assign busy        = (state_reg == ST_GEN);
    assign done        = (state_reg == ST_READY);
    assign rd_cell     = rd_cell_reg;
    assign dst_hit     = dst_hit_reg;
    assign brick_count = brick_count_reg;

endmodule

// File: tb/tb_bomb_map_gen.sv
// Randomized scoreboard bench for bomb_map_gen: a cell-level map model predicts every read
// and destroy response; a separate monitor pops and compares them as the DUT presents them.
module tb_bomb_map_gen;

    localparam int GW = 11;
    localparam int GH = 9;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] rnd;
    logic       start;
    logic       busy;
    logic       done;
    logic [3:0] rd_x, rd_y;
    logic [2:0] rd_cell;
    logic       dst_valid;
    logic [3:0] dst_x, dst_y;
    logic       dst_hit;
    logic [7:0] brick_count;

    bomb_map_gen #(.GRID_W(GW), .GRID_H(GH)) dut (
        .clock(clk), .reset(reset), .rnd(rnd), .start(start),
        .busy(busy), .done(done),
        .rd_x(rd_x), .rd_y(rd_y), .rd_cell(rd_cell),
        .dst_valid(dst_valid), .dst_x(dst_x), .dst_y(dst_y),
        .dst_hit(dst_hit), .brick_count(brick_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        int exp;
    } rd_exp_t;

    int      tests = 0;
    int      fails = 0;
    rd_exp_t rd_q[$];
    int      hit_q[$];
    logic    rd_req = 1'b0, dst_req = 1'b0;
    logic    rd_req_d = 1'b0, dst_req_d = 1'b0;

    int map_m [GH][GW];
    int bc_m = 0;
    bit model_ready = 0;
    int legal [5] = '{2, 4, 8, 6, 5};

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: responses appear one cycle after the request edge.
    always @(posedge clk) begin
        rd_req_d  <= rd_req;
        dst_req_d <= dst_req;
    end

    always @(negedge clk) begin
        rd_exp_t e;
        int h;
        if (rd_req_d) begin
            if (rd_q.size() == 0) begin
                check("rd_queue_underflow", 1, 0);
            end else begin
                e = rd_q.pop_front();
                $display("[TB] rd (%0d,%0d) cell=%0d exp=%0d", e.x, e.y, rd_cell, e.exp);
                check("rd_cell", int'(rd_cell), e.exp);
            end
        end
        if (dst_req_d) begin
            if (hit_q.size() == 0) begin
                check("dst_queue_underflow", 1, 0);
            end else begin
                h = hit_q.pop_front();
                $display("[TB] dst hit=%0d exp=%0d", dst_hit, h);
                check("dst_hit", int'(dst_hit), h);
            end
        end else if (dst_hit) begin
            check("dst_hit_spurious", int'(dst_hit), 0);
        end
    end

    function automatic int rule(input int x, input int y, input int r);
        if ((x % 2 == 1) && (y % 2 == 1)) return 1;
        if ((y == 0 && x <= 1) || (x == 0 && y == 1) || (x == GW-1 && y == GH-1)
            || (x == GW-2 && y == GH-1) || (x == GW-1 && y == GH-2)) return 0;
        if (r == 2 || r == 4) return 2;
        if (r == 8) return 3;
        return 0;
    endfunction

    function automatic int model_cell(input int x, input int y);
        if (x >= GW || y >= GH) return 1;
        return map_m[y][x];
    endfunction

    task automatic step();
        @(negedge clk);
        start     = 1'b0;
        dst_valid = 1'b0;
        rd_req    = 1'b0;
        dst_req   = 1'b0;
    endtask

    task automatic issue_read(input int x, input int y);
        rd_exp_t e;
        rd_x = 4'(x);
        rd_y = 4'(y);
        rd_req = 1'b1;
        e.x = x; e.y = y; e.exp = model_cell(x, y);
        rd_q.push_back(e);
    endtask

    task automatic issue_dst(input int x, input int y);
        int hit = 0;
        dst_x = 4'(x);
        dst_y = 4'(y);
        dst_valid = 1'b1;
        dst_req = 1'b1;
        if (model_ready && !start && x < GW && y < GH) begin
            if (map_m[y][x] == 2) begin
                hit = 1; map_m[y][x] = 0; bc_m--;
            end else if (map_m[y][x] == 3) begin
                hit = 1; map_m[y][x] = 4; bc_m--;
            end
        end
        hit_q.push_back(hit);
    endtask

    task automatic sweep();
        for (int y = 0; y < 16; y++) begin
            for (int x = 0; x < 16; x++) begin
                issue_read(x, y);
                step();
            end
        end
    endtask

    // mode >= 0: constant rnd; mode < 0: random. special: 1 start at cycle 40,
    // 2 reset at cycle 40, 3 destroy (2,0) together with the start pulse.
    task automatic generate_map(input int mode, input int special);
        int rl [GW*GH];
        for (int k = 0; k < GW*GH; k++) begin
            if (mode >= 0) rl[k] = mode;
            else if ($urandom_range(0, 1) == 1) rl[k] = legal[$urandom_range(0, 4)];
            else rl[k] = int'($urandom_range(0, 15));
        end
        $display("[TB] generate mode=%0d special=%0d", mode, special);
        start = 1'b1;
        if (special == 3) issue_dst(2, 0);
        step();
        model_ready = 0;
        check("bc_cleared_on_start", int'(brick_count), 0);
        for (int k = 0; k < GW*GH; k++) begin
            check("busy_in_gen", int'(busy), 1);
            rnd = 4'(rl[k]);
            if (special == 1 && k == 40) start = 1'b1;
            if (special == 2 && k == 40) begin
                reset = 1'b1;
                step();
                reset = 1'b0;
                for (int y = 0; y < GH; y++)
                    for (int x = 0; x < GW; x++) map_m[y][x] = 0;
                bc_m = 0;
                check("busy_after_reset", int'(busy), 0);
                check("done_after_reset", int'(done), 0);
                check("bc_after_reset", int'(brick_count), 0);
                issue_read(2, 0);
                step();
                return;
            end
            step();
        end
        check("done_after_gen", int'(done), 1);
        check("busy_after_gen", int'(busy), 0);
        bc_m = 0;
        for (int y = 0; y < GH; y++) begin
            for (int x = 0; x < GW; x++) begin
                map_m[y][x] = rule(x, y, rl[y*GW + x]);
                if (map_m[y][x] == 2 || map_m[y][x] == 3) bc_m++;
            end
        end
        model_ready = 1;
        check("brick_count_gen", int'(brick_count), bc_m);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation timed out");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; start = 1'b0; rnd = 4'd0;
        rd_x = 4'd0; rd_y = 4'd0; dst_valid = 1'b0; dst_x = 4'd0; dst_y = 4'd0;
        for (int y = 0; y < GH; y++)
            for (int x = 0; x < GW; x++) map_m[y][x] = 0;
        repeat (3) @(negedge clk);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_rd_cell", int'(rd_cell), 0);
        check("reset_dst_hit", int'(dst_hit), 0);
        check("reset_brick_count", int'(brick_count), 0);
        reset = 1'b0;
        issue_read(0, 0); step();
        issue_read(5, 4); step();
        issue_dst(2, 0); step();

        // All-brick map: fixed counts and landmark cells.
        generate_map(2, 0);
        check("bc_all_bricks", int'(brick_count), 73);
        issue_read(1, 1); step();
        issue_read(0, 0); step();
        issue_read(2, 0); step();
        issue_read(10, 8); step();

        // Power-up bricks: destroy twice, second is a no-op.
        generate_map(8, 0);
        issue_dst(2, 0); step();
        issue_read(2, 0); issue_dst(2, 0); step();
        issue_read(2, 0); step();
        step();
        check("bc_after_destroy", int'(brick_count), bc_m);
        check("bc_73_to_72", int'(brick_count), 72);

        // No-brick values.
        generate_map(6, 0);
        sweep();
        check("bc_rnd6", int'(brick_count), 0);
        generate_map(0, 0);
        sweep();
        issue_read(15, 3); step();

        // Same-cycle read and destroy, then a pillar destroy.
        generate_map(2, 0);
        issue_read(4, 2); issue_dst(4, 2); step();
        issue_read(4, 2); step();
        issue_dst(3, 3); step();
        issue_read(3, 3); step();

        // Random map with random destroys, including out-of-range coordinates.
        generate_map(-1, 0);
        for (int i = 0; i < 80; i++) begin
            int x = int'($urandom_range(0, 15));
            int y = int'($urandom_range(0, (i < 60) ? 8 : 15));
            issue_read(x, y);
            issue_dst(x, y);
            step();
        end
        step();
        check("bc_random_destroys", int'(brick_count), bc_m);
        sweep();

        // Start during GEN is ignored.
        generate_map(-1, 1);
        sweep();

        // Reset during GEN discards everything.
        generate_map(-1, 2);
        step();

        // Start and destroy together in READY.
        generate_map(2, 0);
        generate_map(-1, 3);
        sweep();

        repeat (3) step();
        check("rd_queue_drained", rd_q.size(), 0);
        check("dst_queue_drained", hit_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
